// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan reader.
package seg_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned CHAR_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 4;

    // All segments off (active-low segment lines)
    localparam logic [SEG_W-1:0]  SEG_BLANK     = 7'h7F;
    localparam logic [CHAR_W-1:0] ASCII_SPACE   = 8'h20;
    localparam logic [CHAR_W-1:0] ASCII_UNKNOWN = 8'h3F;
    localparam logic [CHAR_W-1:0] ASCII_NUL     = 8'h00;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } out_state_t;

endpackage

// File: rtl/seg7_to_ascii.sv
// Combinational decode of an active-low seven-segment pattern to ASCII.
module seg7_to_ascii
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0]  pattern,
    output logic [CHAR_W-1:0] ascii_c
);

    // Digits take priority where a letter shares a digit's pattern
    always_comb begin
        ascii_c = ASCII_UNKNOWN;
        case (pattern)
            7'h40: ascii_c = 8'h30;
            7'h79: ascii_c = 8'h31;
            7'h24: ascii_c = 8'h32;
            7'h30: ascii_c = 8'h33;
            7'h19: ascii_c = 8'h34;
            7'h12: ascii_c = 8'h35;
            7'h02: ascii_c = 8'h36;
            7'h78: ascii_c = 8'h37;
            7'h00: ascii_c = 8'h38;
            7'h10: ascii_c = 8'h39;
            7'h08: ascii_c = 8'h41;
            7'h03: ascii_c = 8'h42;
            7'h46: ascii_c = 8'h43;
            7'h21: ascii_c = 8'h44;
            7'h06: ascii_c = 8'h45;
            7'h0E: ascii_c = 8'h46;
            7'h09: ascii_c = 8'h48;
            7'h61: ascii_c = 8'h4A;
            7'h47: ascii_c = 8'h4C;
            7'h6A: ascii_c = 8'h4D;
            7'h2B: ascii_c = 8'h4E;
            7'h0C: ascii_c = 8'h50;
            7'h18: ascii_c = 8'h51;
            7'h2F: ascii_c = 8'h52;
            7'h07: ascii_c = 8'h54;
            7'h41: ascii_c = 8'h55;
            7'h63: ascii_c = 8'h56;
            7'h55: ascii_c = 8'h57;
            7'h11: ascii_c = 8'h59;
            7'h7F: ascii_c = ASCII_SPACE;
            default: ascii_c = ASCII_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/seg_scan_reader.sv
// Samples a multiplexed seven-segment display, debounces each digit and
// reports changed characters through a valid/ready event port.
module seg_scan_reader
    import seg_pkg::*;
#(
    parameter int unsigned NDIG   = 8,
    parameter int unsigned STABLE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [NDIG-1:0]        an,
    input  logic [SEG_W-1:0]       seg,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [CHAR_W-1:0]      out_char,
    output logic [IDX_W-1:0]       out_digit,
    output logic [8*NDIG-1:0]      disp,
    output logic                   err
);

    logic                 s_valid;
    logic [IDX_W-1:0]     s_idx;
    logic [SEG_W-1:0]     s_seg;

    logic [SEG_W-1:0]     cand   [NDIG];
    logic [CNT_W-1:0]     cnt    [NDIG];
    logic [CHAR_W-1:0]    disp_r [NDIG];
    logic [NDIG-1:0]      pending;

    logic                 one_low_c;
    logic                 multi_low_c;
    logic [IDX_W-1:0]     an_idx_c;
    logic [CHAR_W-1:0]    dec_c;
    logic [NDIG-1:0]      set_mask;
    logic [NDIG-1:0]      clr_mask;
    logic [IDX_W-1:0]     low_idx_c;
    logic [CHAR_W-1:0]    low_char_c;

    out_state_t           state;

    // Classify the digit-select lines and locate the selected digit
    always_comb begin
        one_low_c   = ($countones(~an) == 1);
        multi_low_c = ($countones(~an) > 1);
        an_idx_c    = '0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (!an[i]) an_idx_c = IDX_W'(i);
        end
    end

    // Sample registers and the multi-select error pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_valid <= 1'b0;
            s_idx   <= '0;
            s_seg   <= '0;
            err     <= 1'b0;
        end else begin
            s_valid <= en && one_low_c;
            err     <= en && multi_low_c;
            if (en) begin
                s_idx <= an_idx_c;
                s_seg <= seg;
            end
        end
    end

    // Only the sampled digit can be accepted this cycle, so one decoder serves all
    seg7_to_ascii u_dec (
        .pattern (s_seg),
        .ascii_c (dec_c)
    );

    // Acceptance of a changed character, and handshake release of a pending event
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int k = 0; k < int'(NDIG); k++) begin
            set_mask[k] = s_valid && (s_idx == IDX_W'(k)) && (s_seg == cand[k])
                          && (cnt[k] == CNT_W'(STABLE - 1)) && (dec_c != disp_r[k]);
            clr_mask[k] = (state == ST_PRESENT) && out_ready && (out_digit == IDX_W'(k));
        end
    end

    // Per-digit debounce, accepted display and pending events; a same-cycle set beats a clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(NDIG); k++) begin
                cand[k]   <= SEG_BLANK;
                cnt[k]    <= '0;
                disp_r[k] <= ASCII_SPACE;
            end
            pending <= '0;
        end else begin
            for (int k = 0; k < int'(NDIG); k++) begin
                if (s_valid && (s_idx == IDX_W'(k))) begin
                    if (s_seg == cand[k]) begin
                        if (cnt[k] != CNT_W'(STABLE)) cnt[k] <= cnt[k] + CNT_W'(1);
                    end else begin
                        cand[k] <= s_seg;
                        cnt[k]  <= CNT_W'(1);
                    end
                end
                if (set_mask[k]) disp_r[k] <= dec_c;
            end
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    // Lowest-index pending digit and its current character
    always_comb begin
        low_idx_c  = '0;
        low_char_c = ASCII_NUL;
        for (int i = int'(NDIG) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx_c  = IDX_W'(i);
                low_char_c = disp_r[i];
            end
        end
    end

    // Event presentation FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_char  <= ASCII_NUL;
            out_digit <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|pending) begin
                        state     <= ST_PRESENT;
                        out_valid <= 1'b1;
                        out_digit <= low_idx_c;
                        out_char  <= low_char_c;
                    end
                end
                ST_PRESENT: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Flatten the accepted characters onto the display bus
    for (genvar g = 0; g < int'(NDIG); g++) begin : g_disp
        assign disp[8*g +: 8] = disp_r[g];
    end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Self-checking bench for seg_scan_reader: directed scenarios plus a randomized
// scan checked against a run-length / event-list reference model.
module tb_seg_scan_reader;

    localparam int NDIG   = 8;
    localparam int STABLE = 4;

    logic                clk;
    logic                rst_n;
    logic                en;
    logic [NDIG-1:0]     an;
    logic [6:0]          seg;
    logic                out_ready;
    logic                out_valid;
    logic [7:0]          out_char;
    logic [2:0]          out_digit;
    logic [8*NDIG-1:0]   disp;
    logic                err;

    int vectors;
    int miscompares;

    seg_scan_reader #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .an        (an),
        .seg       (seg),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_char  (out_char),
        .out_digit (out_digit),
        .disp      (disp),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: run length of the last pattern seen per digit,
    // accepted character per digit, and outstanding (unreported) changes.
    int          run    [NDIG];
    logic [6:0]  last   [NDIG];
    logic [7:0]  m_disp [NDIG];
    bit          outst  [NDIG];
    bit          p_en;
    logic [NDIG-1:0] p_an;
    logic [6:0]  p_seg;
    bit          exp_err;

    bit          pre_valid;
    bit          pre_hs;
    logic [2:0]  pre_dig;
    logic [7:0]  pre_och;
    int          pre_lo;
    logic [7:0]  pre_ch;

    function automatic logic [7:0] ref_decode(input logic [6:0] p);
        case (p)
            7'h40: return "0";  7'h79: return "1";  7'h24: return "2";
            7'h30: return "3";  7'h19: return "4";  7'h12: return "5";
            7'h02: return "6";  7'h78: return "7";  7'h00: return "8";
            7'h10: return "9";  7'h08: return "A";  7'h03: return "B";
            7'h46: return "C";  7'h21: return "D";  7'h06: return "E";
            7'h0E: return "F";  7'h09: return "H";  7'h61: return "J";
            7'h47: return "L";  7'h6A: return "M";  7'h2B: return "N";
            7'h0C: return "P";  7'h18: return "Q";  7'h2F: return "R";
            7'h07: return "T";  7'h41: return "U";  7'h63: return "V";
            7'h55: return "W";  7'h11: return "Y";  7'h7F: return " ";
            default: return "?";
        endcase
    endfunction

    function automatic int count_low(input logic [NDIG-1:0] a);
        return $countones(~a);
    endfunction

    function automatic logic [8*NDIG-1:0] model_disp_vec();
        logic [8*NDIG-1:0] v;
        for (int k = 0; k < NDIG; k++) v[8*k +: 8] = m_disp[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDIG; k++) begin
            run[k]    = 0;
            last[k]   = 7'h7F;
            m_disp[k] = 8'h20;
            outst[k]  = 1'b0;
        end
        p_en    = 1'b0;
        p_an    = '1;
        p_seg   = 7'h7F;
        exp_err = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        an        = '1;
        seg       = 7'h7F;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    // Drive one cycle of inputs, advance one edge, and advance the model.
    // A sample applied at edge t affects the accepted display at edge t+1.
    task automatic step(input logic e, input logic [NDIG-1:0] a, input logic [6:0] s, input logic r);
        int k;
        en        = e;
        an        = a;
        seg       = s;
        out_ready = r;
        pre_valid = out_valid;
        pre_hs    = out_valid && r;
        pre_dig   = out_digit;
        pre_och   = out_char;
        pre_lo    = -1;
        for (int i = NDIG - 1; i >= 0; i--) if (outst[i]) pre_lo = i;
        pre_ch = 8'h00;
        if (pre_lo >= 0) pre_ch = m_disp[pre_lo];
        @(posedge clk);
        #1;
        if (pre_hs) outst[pre_dig] = 1'b0;
        if (p_en && count_low(p_an) == 1) begin
            k = 0;
            for (int i = 0; i < NDIG; i++) if (!p_an[i]) k = i;
            if (p_seg == last[k]) begin
                run[k]++;
            end else begin
                last[k] = p_seg;
                run[k]  = 1;
            end
            if (run[k] == STABLE && ref_decode(last[k]) != m_disp[k]) begin
                m_disp[k] = ref_decode(last[k]);
                outst[k]  = 1'b1;
            end
        end
        exp_err = e && (count_low(a) > 1);
        p_en  = e;
        p_an  = a;
        p_seg = s;
    endtask

    task automatic idle(input logic r);
        step(1'b0, '1, 7'h7F, r);
    endtask

    task automatic drain();
        repeat (24) idle(1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        vectors++;
        if (out_char !== 8'h00 || out_digit !== 3'd0) begin
            miscompares++; $display("FAIL reset_out: got char %h digit %0d expected 00 / 0", out_char, out_digit);
        end
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err); end
        vectors++;
        if (disp !== {NDIG{8'h20}}) begin miscompares++; $display("FAIL reset_disp: got %h expected all 20", disp); end
    endtask

    task automatic test_basic_latency();
        repeat (4) step(1'b1, 8'hFE, 7'h24, 1'b1);
        idle(1'b1);
        vectors++;
        if (disp[7:0] !== 8'h32 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL latency_disp: got disp0 %h valid %b expected 32 / 0", disp[7:0], out_valid);
        end
        idle(1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_char !== 8'h32 || out_digit !== 3'd0) begin
            miscompares++;
            $display("FAIL latency_event: got valid %b char %h digit %0d expected 1 / 32 / 0", out_valid, out_char, out_digit);
        end
        idle(1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL latency_ack: got valid %b expected 0", out_valid); end
        drain();
    endtask

    task automatic test_no_event();
        bit seen;
        seen = 1'b0;
        repeat (3) begin step(1'b1, 8'hFD, 7'h08, 1'b1); seen |= out_valid; end
        step(1'b1, 8'hFD, 7'h03, 1'b1); seen |= out_valid;
        repeat (8) begin idle(1'b1); seen |= out_valid; end
        vectors++;
        if (seen || disp[15:8] !== 8'h20) begin
            miscompares++; $display("FAIL short_run: got seen %b disp1 %h expected 0 / 20", seen, disp[15:8]);
        end
    endtask

    task automatic test_priority_hold();
        repeat (4) step(1'b1, 8'h7F, 7'h79, 1'b0);
        repeat (2) idle(1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_digit !== 3'd7 || out_char !== 8'h31) begin
            miscompares++;
            $display("FAIL prio_first: got valid %b digit %0d char %h expected 1 / 7 / 31", out_valid, out_digit, out_char);
        end
        repeat (4) step(1'b1, 8'hF7, 7'h40, 1'b0);
        repeat (4) step(1'b1, 8'hFE, 7'h40, 1'b0);
        repeat (2) idle(1'b0);
        idle(1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL prio_ack7: got valid %b expected 0", out_valid); end
        idle(1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_digit !== 3'd0 || out_char !== 8'h30) begin
            miscompares++;
            $display("FAIL prio_lowest: got valid %b digit %0d char %h expected 1 / 0 / 30", out_valid, out_digit, out_char);
        end
        for (int i = 0; i < 10; i++) begin
            idle(1'b0);
            vectors++;
            if (out_valid !== 1'b1 || out_digit !== 3'd0 || out_char !== 8'h30) begin
                miscompares++;
                $display("FAIL prio_hold%0d: got valid %b digit %0d char %h expected 1 / 0 / 30", i, out_valid, out_digit, out_char);
            end
        end
        idle(1'b1);
        idle(1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_digit !== 3'd3 || out_char !== 8'h30) begin
            miscompares++;
            $display("FAIL prio_second: got valid %b digit %0d char %h expected 1 / 3 / 30", out_valid, out_digit, out_char);
        end
        drain();
    endtask

    task automatic test_err();
        repeat (2) step(1'b1, 8'hEF, 7'h12, 1'b1);
        step(1'b1, 8'hFC, 7'h12, 1'b1);
        vectors++;
        if (err !== 1'b1) begin miscompares++; $display("FAIL err_pulse: got %b expected 1", err); end
        step(1'b1, 8'hEF, 7'h12, 1'b1);
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL err_clear: got %b expected 0", err); end
        step(1'b1, 8'hEE, 7'h40, 1'b1);
        vectors++;
        if (err !== 1'b1) begin miscompares++; $display("FAIL err_pulse2: got %b expected 1", err); end
        step(1'b1, 8'hEF, 7'h12, 1'b1);
        repeat (2) idle(1'b1);
        vectors++;
        if (disp[39:32] !== 8'h35 || err !== 1'b0) begin
            miscompares++; $display("FAIL err_keep_count: got disp4 %h err %b expected 35 / 0", disp[39:32], err);
        end
        drain();
    endtask

    task automatic test_unknown_blank();
        bit seen;
        repeat (4) step(1'b1, 8'hFB, 7'h7E, 1'b0);
        repeat (2) idle(1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_digit !== 3'd2 || out_char !== 8'h3F) begin
            miscompares++;
            $display("FAIL unknown_event: got valid %b digit %0d char %h expected 1 / 2 / 3f", out_valid, out_digit, out_char);
        end
        idle(1'b1);
        repeat (4) step(1'b1, 8'hFB, 7'h7F, 1'b0);
        repeat (2) idle(1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_digit !== 3'd2 || out_char !== 8'h20) begin
            miscompares++;
            $display("FAIL blank_event: got valid %b digit %0d char %h expected 1 / 2 / 20", out_valid, out_digit, out_char);
        end
        idle(1'b1);
        seen = 1'b0;
        repeat (6) begin step(1'b1, 8'hFB, 7'h7F, 1'b1); seen |= out_valid; end
        repeat (4) begin idle(1'b1); seen |= out_valid; end
        vectors++;
        if (seen || disp[23:16] !== 8'h20) begin
            miscompares++; $display("FAIL blank_repeat: got seen %b disp2 %h expected 0 / 20", seen, disp[23:16]);
        end
    endtask

    task automatic test_reset_present();
        bit seen;
        repeat (4) step(1'b1, 8'hBF, 7'h02, 1'b0);
        repeat (4) step(1'b1, 8'hFD, 7'h19, 1'b0);
        repeat (2) idle(1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_digit !== 3'd6 || out_char !== 8'h36) begin
            miscompares++;
            $display("FAIL rstp_event: got valid %b digit %0d char %h expected 1 / 6 / 36", out_valid, out_digit, out_char);
        end
        do_reset();
        vectors++;
        if (out_valid !== 1'b0 || disp !== {NDIG{8'h20}}) begin
            miscompares++; $display("FAIL rstp_drop: got valid %b disp %h expected 0 / all 20", out_valid, disp);
        end
        seen = 1'b0;
        repeat (6) begin idle(1'b1); seen |= out_valid; end
        vectors++;
        if (seen) begin miscompares++; $display("FAIL rstp_pending: got event after reset expected none"); end
    endtask

    task automatic test_random();
        logic [6:0] pool [8];
        logic [6:0] pat  [NDIG];
        logic [NDIG-1:0] a;
        logic [6:0] s;
        logic e, r;
        int d, kind;
        pool[0] = 7'h40; pool[1] = 7'h79; pool[2] = 7'h24; pool[3] = 7'h30;
        pool[4] = 7'h08; pool[5] = 7'h7E; pool[6] = 7'h7F; pool[7] = 7'h00;
        for (int k = 0; k < NDIG; k++) pat[k] = pool[$urandom_range(0, 7)];
        do_reset();
        for (int c = 0; c < 1200; c++) begin
            d = $urandom_range(0, NDIG - 1);
            if ($urandom_range(0, 29) == 0) begin
                if ($urandom_range(0, 3) == 0) pat[d] = 7'($urandom);
                else pat[d] = pool[$urandom_range(0, 7)];
            end
            kind = $urandom_range(0, 19);
            e = 1'b1;
            a = ~(NDIG'(1) << d);
            if (kind == 0) a = '1;
            else if (kind == 1) e = 1'b0;
            else if (kind == 2) a = ~((NDIG'(1) << d) | (NDIG'(1) << ((d + 1) % NDIG)));
            s = ($urandom_range(0, 15) == 0) ? 7'($urandom) : pat[d];
            r = ($urandom_range(0, 2) != 0);
            step(e, a, s, r);
            vectors++;
            if (disp !== model_disp_vec()) begin
                miscompares++; $display("FAIL rnd_disp c%0d: got %h expected %h", c, disp, model_disp_vec());
            end
            vectors++;
            if (err !== exp_err) begin miscompares++; $display("FAIL rnd_err c%0d: got %b expected %b", c, err, exp_err); end
            vectors++;
            if (pre_hs) begin
                if (out_valid !== 1'b0) begin
                    miscompares++; $display("FAIL rnd_ack c%0d: got valid %b expected 0", c, out_valid);
                end
            end else if (pre_valid) begin
                if (out_valid !== 1'b1 || out_digit !== pre_dig || out_char !== pre_och) begin
                    miscompares++;
                    $display("FAIL rnd_hold c%0d: got %b/%0d/%h expected 1/%0d/%h", c, out_valid, out_digit, out_char, pre_dig, pre_och);
                end
            end else if (pre_lo < 0) begin
                if (out_valid !== 1'b0) begin
                    miscompares++; $display("FAIL rnd_spurious c%0d: got valid %b expected 0", c, out_valid);
                end
            end else begin
                if (out_valid !== 1'b1 || out_digit !== 3'(pre_lo) || out_char !== pre_ch) begin
                    miscompares++;
                    $display("FAIL rnd_present c%0d: got %b/%0d/%h expected 1/%0d/%h", c, out_valid, out_digit, out_char, pre_lo, pre_ch);
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        en          = 1'b0;
        an          = '1;
        seg         = 7'h7F;
        out_ready   = 1'b0;
        model_reset();
        test_reset();
        test_basic_latency();
        test_no_event();
        test_priority_hold();
        test_err();
        test_unknown_blank();
        test_reset_present();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
